// File: rtl/mem_stage_if.sv
// Word-wide data memory port between the memory stage (master) and the data memory (slave).
// mem_req and the request fields stay stable until mem_ack; mem_rdata is valid with mem_ack.
interface mem_stage_if #(
  parameter int ARCH_BITS = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ARCH_BITS-1:0] mem_addr;
  logic [3:0]           mem_be;
  logic [ARCH_BITS-1:0] mem_wdata;
  logic                 mem_ack;
  logic [ARCH_BITS-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU results pass through, loads/stores run a req/ack bus transaction.
// Optional ack watchdog with FAULT state enabled by defining MEM_STAGE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accept ops from the ALU stage; pass-through or start a bus transaction
// WAIT  | request held on the bus until mem_ack
// FAULT | one cycle reporting an ack timeout (MEM_STAGE_TIMEOUT_EN only)
module mem_stage #(
  parameter int ARCH_BITS      = 32,
  parameter int OPC_BITS       = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [OPC_BITS-1:0]  opcode_in,
  input  logic [ARCH_BITS-1:0] result_in,
  input  logic [ARCH_BITS-1:0] store_data_in,
  input  logic [4:0]           dst_in,
  output logic                 stall_out,
  output logic                 valid_out,
  output logic [OPC_BITS-1:0]  opcode_out,
  output logic [ARCH_BITS-1:0] wdata_out,
  output logic [4:0]           dst_out,
  output logic                 except_out,
  output logic [ARCH_BITS-1:0] except_addr,
  mem_stage_if.master          mem
);

  localparam logic [OPC_BITS-1:0] OP_LDB = OPC_BITS'('h10);
  localparam logic [OPC_BITS-1:0] OP_LDW = OPC_BITS'('h11);
  localparam logic [OPC_BITS-1:0] OP_STB = OPC_BITS'('h12);
  localparam logic [OPC_BITS-1:0] OP_STW = OPC_BITS'('h13);
  localparam logic [OPC_BITS-1:0] OP_NOP = OPC_BITS'('h7F);

`ifdef MEM_STAGE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WAIT, FAULT} stateT;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cntQ, cntNext;
`else
  typedef enum logic [0:0] {IDLE, WAIT} stateT;
`endif

  stateT state, stateNext;

  logic                 validQ, validNext;
  logic [OPC_BITS-1:0]  opcQ, opcNext;
  logic [ARCH_BITS-1:0] wdataQ, wdataNext;
  logic [4:0]           dstQ, dstNext;
  logic                 excQ, excNext;
  logic [ARCH_BITS-1:0] excAddrQ, excAddrNext;
  logic                 memReqQ, memReqNext;
  logic                 memWeQ, memWeNext;
  logic [ARCH_BITS-1:0] memAddrQ, memAddrNext;
  logic [3:0]           memBeQ, memBeNext;
  logic [ARCH_BITS-1:0] memWdataQ, memWdataNext;
  logic [OPC_BITS-1:0]  pendOpcQ, pendOpcNext;
  logic [4:0]           pendDstQ, pendDstNext;
  logic [1:0]           pendLaneQ, pendLaneNext;

  logic isMem, isWordOp, misaligned;

  assign isMem      = opcode_in inside {OP_LDB, OP_LDW, OP_STB, OP_STW};
  assign isWordOp   = (opcode_in == OP_LDW) || (opcode_in == OP_STW);
  assign misaligned = isWordOp && (result_in[1:0] != 2'b00);

  always_comb begin
    stateNext    = state;
    validNext    = 1'b0;
    opcNext      = OP_NOP;
    wdataNext    = wdataQ;
    dstNext      = dstQ;
    excNext      = 1'b0;
    excAddrNext  = excAddrQ;
    memReqNext   = memReqQ;
    memWeNext    = memWeQ;
    memAddrNext  = memAddrQ;
    memBeNext    = memBeQ;
    memWdataNext = memWdataQ;
    pendOpcNext  = pendOpcQ;
    pendDstNext  = pendDstQ;
    pendLaneNext = pendLaneQ;
    stall_out    = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
    cntNext      = cntQ;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (!isMem) begin
            validNext = 1'b1;
            opcNext   = opcode_in;
            wdataNext = result_in;
            dstNext   = dst_in;
          end else if (misaligned) begin
            validNext   = 1'b1;
            excNext     = 1'b1;
            excAddrNext = result_in;
            wdataNext   = '0;
          end else begin
            stall_out    = 1'b1;
            memReqNext   = 1'b1;
            memWeNext    = (opcode_in == OP_STB) || (opcode_in == OP_STW);
            memAddrNext  = {result_in[ARCH_BITS-1:2], 2'b00};
            memBeNext    = isWordOp ? 4'hF : (4'b0001 << result_in[1:0]);
            memWdataNext = (opcode_in == OP_STW) ? store_data_in :
                           (opcode_in == OP_STB) ? {(ARCH_BITS/8){store_data_in[7:0]}} : '0;
            pendOpcNext  = opcode_in;
            pendDstNext  = dst_in;
            pendLaneNext = result_in[1:0];
            stateNext    = WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
            cntNext      = '0;
`endif
          end
        end
      end
      WAIT: begin
        stall_out = !mem.mem_ack;
        if (mem.mem_ack) begin
          memReqNext = 1'b0;
          validNext  = 1'b1;
          opcNext    = pendOpcQ;
          dstNext    = pendDstQ;
          if (pendOpcQ == OP_LDW)
            wdataNext = mem.mem_rdata;
          else if (pendOpcQ == OP_LDB)
            wdataNext = {{(ARCH_BITS-8){1'b0}}, mem.mem_rdata[{pendLaneQ, 3'b000} +: 8]};
          else
            wdataNext = '0;
          stateNext = IDLE;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        // an ack on the limit cycle completes normally; the watchdog only fires without one
        else if (cntQ == LIMIT) begin
          memReqNext  = 1'b0;
          validNext   = 1'b1;
          excNext     = 1'b1;
          excAddrNext = {memAddrQ[ARCH_BITS-1:2], pendLaneQ};
          stateNext   = FAULT;
        end else begin
          cntNext = cntQ + CW'(1);
        end
      end
      FAULT: begin
        stall_out = 1'b1;
        stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      validQ    <= 1'b0;
      opcQ      <= OP_NOP;
      wdataQ    <= '0;
      dstQ      <= '0;
      excQ      <= 1'b0;
      excAddrQ  <= '0;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memBeQ    <= '0;
      memWdataQ <= '0;
      pendOpcQ  <= OP_NOP;
      pendDstQ  <= '0;
      pendLaneQ <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      cntQ      <= '0;
`endif
    end else begin
      state     <= stateNext;
      validQ    <= validNext;
      opcQ      <= opcNext;
      wdataQ    <= wdataNext;
      dstQ      <= dstNext;
      excQ      <= excNext;
      excAddrQ  <= excAddrNext;
      memReqQ   <= memReqNext;
      memWeQ    <= memWeNext;
      memAddrQ  <= memAddrNext;
      memBeQ    <= memBeNext;
      memWdataQ <= memWdataNext;
      pendOpcQ  <= pendOpcNext;
      pendDstQ  <= pendDstNext;
      pendLaneQ <= pendLaneNext;
`ifdef MEM_STAGE_TIMEOUT_EN
      cntQ      <= cntNext;
`endif
    end
  end

  assign valid_out     = validQ;
  assign opcode_out    = opcQ;
  assign wdata_out     = wdataQ;
  assign dst_out       = dstQ;
  assign except_out    = excQ;
  assign except_addr   = excAddrQ;
  assign mem.mem_req   = memReqQ;
  assign mem.mem_we    = memWeQ;
  assign mem.mem_addr  = memAddrQ;
  assign mem.mem_be    = memBeQ;
  assign mem.mem_wdata = memWdataQ;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random op stream against a word-level memory model,
// with a bus responder checking requests and a monitor checking writeback outputs.
module tb_mem_stage;

  localparam logic [6:0] LDB = 7'h10, LDW = 7'h11, STB = 7'h12, STW = 7'h13, NOP = 7'h7F;

  logic        clk, rst;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [31:0] result_in, store_data_in;
  logic [4:0]  dst_in;
  logic        stall_out, valid_out, except_out;
  logic [6:0]  opcode_out;
  logic [31:0] wdata_out, except_addr;
  logic [4:0]  dst_out;

  mem_stage_if #(.ARCH_BITS(32)) mbus ();

  mem_stage #(.ARCH_BITS(32), .OPC_BITS(7), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode_in(opcode_in),
    .result_in(result_in), .store_data_in(store_data_in), .dst_in(dst_in),
    .stall_out(stall_out), .valid_out(valid_out), .opcode_out(opcode_out),
    .wdata_out(wdata_out), .dst_out(dst_out), .except_out(except_out),
    .except_addr(except_addr), .mem(mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [31:0] data;
    logic [4:0]  dst;
    logic        exc;
    logic [31:0] excAddr;
  } wbExpT;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chkData;
    int          delay;
  } reqExpT;

  wbExpT  wbQ[$];
  reqExpT reqQ[$];

  logic [31:0] modelMem [logic [31:0]];
  logic [31:0] busMem   [logic [31:0]];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F96;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    return modelMem.exists(a) ? modelMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] busRead(input logic [31:0] a);
    return busMem.exists(a) ? busMem[a] : initWord(a);
  endfunction

  task automatic setWord(input logic [31:0] a, input logic [31:0] v);
    modelMem[a] = v;
    busMem[a]   = v;
  endtask

  // Expected results come from the architectural meaning of each opcode.
  task automatic issueOp(input logic [6:0] opc, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] dst, input int delay);
    wbExpT e;
    reqExpT r;
    logic [31:0] wa, w;
    int lane, n;
    bit memOp, misal;
    wa    = {addr[31:2], 2'b00};
    lane  = int'(addr[1:0]);
    w     = modelRead(wa);
    memOp = (opc >= LDB) && (opc <= STW);
    misal = ((opc == LDW) || (opc == STW)) && (lane != 0);
    e.opc = opc; e.data = addr; e.dst = dst; e.exc = 1'b0; e.excAddr = 32'h0;
    r.we = 1'b0; r.addr = wa; r.be = 4'hF; r.wdata = 32'h0; r.chkData = 1'b0; r.delay = delay;
    if (misal) begin
      e.opc = NOP; e.exc = 1'b1; e.excAddr = addr;
    end else if (memOp) begin
      case (opc)
        LDB: begin r.be = 4'(1 << lane); e.data = (w >> (8 * lane)) & 32'hFF; end
        LDW: e.data = w;
        STB: begin
          r.we = 1'b1; r.be = 4'(1 << lane); r.chkData = 1'b1;
          r.wdata = 32'(sdata[7:0]) * 32'h0101_0101;
          e.data = 32'h0;
          modelMem[wa] = (w & ~(32'hFF << (8 * lane))) | (32'(sdata[7:0]) << (8 * lane));
        end
        STW: begin
          r.we = 1'b1; r.wdata = sdata; r.chkData = 1'b1; e.data = 32'h0;
          modelMem[wa] = sdata;
        end
        default: ;
      endcase
      reqQ.push_back(r);
    end
    wbQ.push_back(e);
    valid_in = 1'b1; opcode_in = opc; result_in = addr; store_data_in = sdata; dst_in = dst;
    @(negedge clk);
    check("stall_on_issue", stall_out, memOp && !misal);
    n = 0;
    while (stall_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (stall_out) check("stall_release_timeout", stall_out, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("valid_after_accept", valid_out, 1);
  endtask

  // Writeback monitor
  initial begin
    wbExpT e;
    forever begin
      @(negedge clk);
      if (!rst && valid_out) begin
        if (wbQ.size() == 0) check("unexpected_valid_out", 1, 0);
        else begin
          e = wbQ.pop_front();
          check("wb_opcode", opcode_out, e.opc);
          check("wb_except", except_out, e.exc);
          if (e.exc) check("wb_except_addr", except_addr, e.excAddr);
          else begin
            check("wb_data", wdata_out, e.data);
            check("wb_dst", dst_out, e.dst);
          end
        end
      end else if (!rst && except_out) check("except_without_valid", except_out, 0);
    end
  end

  // Bus responder: checks each request, holds it for a chosen delay, then acks
  initial begin
    reqExpT cur;
    bit active;
    int held;
    logic [71:0] snap;
    logic [31:0] bw;
    active = 0; held = 0;
    mbus.mem_ack = 1'b0; mbus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mbus.mem_ack = 1'b0;
      if (rst || !mbus.mem_req) begin
        active = 0;
        if (!rst && $urandom_range(0, 3) == 0) begin
          mbus.mem_ack   = 1'b1;
          mbus.mem_rdata = $urandom;
        end
      end else begin
        if (!active) begin
          if (reqQ.size() == 0) check("unexpected_mem_req", 1, 0);
          else begin
            cur = reqQ.pop_front();
            active = 1; held = 0;
            check("req_we", mbus.mem_we, cur.we);
            check("req_addr", mbus.mem_addr, cur.addr);
            check("req_be", mbus.mem_be, cur.be);
            if (cur.chkData) check("req_wdata", mbus.mem_wdata, cur.wdata);
            snap = {3'b0, mbus.mem_we, mbus.mem_be, mbus.mem_addr, mbus.mem_wdata};
          end
        end else begin
          check("req_held_stable",
                {3'b0, mbus.mem_we, mbus.mem_be, mbus.mem_addr, mbus.mem_wdata} === snap, 1);
        end
        if (active) begin
          if (held == cur.delay) begin
            mbus.mem_ack = 1'b1;
            if (mbus.mem_we) begin
              bw = busRead(mbus.mem_addr);
              for (int b = 0; b < 4; b++)
                if (mbus.mem_be[b]) bw[8*b +: 8] = mbus.mem_wdata[8*b +: 8];
              busMem[mbus.mem_addr] = bw;
            end else begin
              mbus.mem_rdata = busRead(mbus.mem_addr);
            end
            active = 0;
          end
          held++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reqExpT r;
    wbExpT e;
    logic [6:0] opc;
    logic [31:0] addr;
    rst = 1'b1; valid_in = 1'b0; opcode_in = NOP; result_in = 32'h0;
    store_data_in = 32'h0; dst_in = 5'd0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_opcode_out", opcode_out, NOP);
    check("rst_wdata_out", wdata_out, 0);
    check("rst_dst_out", dst_out, 0);
    check("rst_except_out", except_out, 0);
    check("rst_except_addr", except_addr, 0);
    check("rst_mem_req", mbus.mem_req, 0);
    check("rst_mem_we", mbus.mem_we, 0);
    check("rst_mem_be", mbus.mem_be, 0);
    check("rst_mem_addr", mbus.mem_addr, 0);
    check("rst_mem_wdata", mbus.mem_wdata, 0);
    check("rst_stall_out", stall_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    issueOp(7'h00, 32'h0000_1234, 32'h0, 5'd3, 0);
    setWord(32'h8004, 32'hDEAD_BEEF);
    issueOp(LDW, 32'h0000_8004, 32'h0, 5'd5, 2);
    setWord(32'h8004, 32'hAABB_CCDD);
    issueOp(LDB, 32'h0000_8006, 32'h0, 5'd6, 1);
    issueOp(STB, 32'h0000_9003, 32'h0000_005A, 5'd0, 0);
    issueOp(LDW, 32'h0000_9000, 32'h0, 5'd7, 0);
    issueOp(STW, 32'h0000_9002, 32'h1234_5678, 5'd0, 0);
    issueOp(LDW, 32'h0000_8004, 32'h0, 5'd8, 0);
    issueOp(LDW, 32'h0000_8008, 32'h0, 5'd9, 0);

    // reset while a load is waiting for ack: transaction abandoned, no writeback
    r.we = 1'b0; r.addr = 32'h8010; r.be = 4'hF; r.wdata = 32'h0; r.chkData = 1'b0; r.delay = 20;
    reqQ.push_back(r);
    valid_in = 1'b1; opcode_in = LDW; result_in = 32'h8010; dst_in = 5'd9;
    n = 0;
    @(negedge clk);
    while (!mbus.mem_req && n < 10) begin @(negedge clk); n++; end
    check("midwait_req_seen", mbus.mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midwait_reset_mem_req", mbus.mem_req, 0);
    check("midwait_reset_valid_out", valid_out, 0);
    @(posedge clk); #1;

`ifdef MEM_STAGE_TIMEOUT_EN
    issueOp(LDW, 32'h0000_8024, 32'h0, 5'd10, 63);
    r.we = 1'b0; r.addr = 32'h8020; r.be = 4'hF; r.wdata = 32'h0; r.chkData = 1'b0; r.delay = 100000;
    reqQ.push_back(r);
    e.opc = NOP; e.data = 32'h0; e.dst = 5'd0; e.exc = 1'b1; e.excAddr = 32'h8020;
    wbQ.push_back(e);
    valid_in = 1'b1; opcode_in = LDW; result_in = 32'h8020; dst_in = 5'd11;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 200 && !except_out; i++) begin
      if (mbus.mem_req) n++;
      @(negedge clk);
    end
    check("timeout_except_seen", except_out, 1);
    check("timeout_req_cycles", n, 64);
    check("timeout_stall_in_fault", stall_out, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("timeout_except_one_cycle", except_out, 0);
    check("timeout_req_dropped", mbus.mem_req, 0);
    @(posedge clk); #1;
`endif

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1: opc = LDB;
        2, 3: opc = LDW;
        4:    opc = STB;
        5:    opc = STW;
        6:    opc = NOP;
        default: begin
          opc = 7'($urandom_range(0, 127));
          if (opc >= LDB && opc <= STW) opc = 7'h20;
        end
      endcase
      if (opc >= LDB && opc <= STW) begin
        addr = 32'h8000 + $urandom_range(0, 255);
        if ((opc == LDW || opc == STW) && $urandom_range(0, 9) < 7) addr[1:0] = 2'b00;
      end else begin
        addr = $urandom;
      end
      issueOp(opc, addr, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 4));
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while ((wbQ.size() != 0 || reqQ.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", wbQ.size() + reqQ.size(), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
